// File: rtl/lcd_string_writer.sv
// HD44780 16x2 character LCD writer: power-up wait, init commands, then two lines of
// 16 characters fetched from an external string lookup, redrawn on refresh.
module lcd_string_writer #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_CYC      = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_CYC    = 2500,
  parameter int unsigned CLEAR_CYC   = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh,
  output logic [4:0] char_index,
  input  logic [7:0] char_data,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       busy,
  output logic       done
);

  localparam int unsigned M1   = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
  localparam int unsigned M2   = (M1 > EN_CYC) ? M1 : EN_CYC;
  localparam int unsigned M3   = (M2 > HOLD_CYC) ? M2 : HOLD_CYC;
  localparam int unsigned M4   = (M3 > EXEC_CYC) ? M3 : EXEC_CYC;
  localparam int unsigned MAXN = (M4 > CLEAR_CYC) ? M4 : CLEAR_CYC;
  localparam int          CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT, ST_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    step_q, step_d;
  logic [4:0]    ci_q, ci_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          on_q;
  logic          done_q, done_d;
  logic          pend_q, pend_d;
  logic          go_setup;
  logic [5:0]    nstep;

  // Steps 5..20 are line 1 characters, 22..37 line 2; everything else is a command.
  function automatic logic is_char(input logic [5:0] s);
    return ((s >= 6'd5) && (s <= 6'd20)) || (s >= 6'd22);
  endfunction

  function automatic logic [4:0] char_idx(input logic [5:0] s);
    logic [5:0] t;
    t = (s <= 6'd20) ? (s - 6'd5) : (s - 6'd6);
    return t[4:0];
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [5:0] s);
    case (s)
      6'd0:    return 8'h38;
      6'd1:    return 8'h0C;
      6'd2:    return 8'h01;
      6'd3:    return 8'h06;
      6'd4:    return 8'h80;
      6'd21:   return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    ci_d     = ci_q;
    data_d   = data_q;
    rs_d     = rs_q;
    en_d     = en_q;
    done_d   = done_q;
    pend_d   = pend_q | (refresh & (state_q != ST_IDLE));
    go_setup = 1'b0;
    nstep    = step_q;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == '0) go_setup = 1'b1;
        else             cnt_d = cnt_q - CW'(1);
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          if (is_char(step_q)) begin
            data_d = char_data;
            rs_d   = 1'b1;
          end
          state_d = ST_PULSE;
          en_d    = 1'b1;
          cnt_d   = CW'(EN_CYC - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          en_d    = 1'b0;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = (step_q == 6'd2) ? CW'(CLEAR_CYC - 1) : CW'(EXEC_CYC - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (step_q == 6'd37) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            go_setup = 1'b1;
            nstep    = step_q + 6'd1;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_IDLE: begin
        // A request latched while busy is honoured here, giving a one-cycle IDLE.
        if (refresh || pend_q) begin
          go_setup = 1'b1;
          nstep    = 6'd4;
          done_d   = 1'b0;
          pend_d   = 1'b0;
        end
      end
      default: state_d = ST_POWERUP;
    endcase

    if (go_setup) begin
      state_d = ST_SETUP;
      step_d  = nstep;
      cnt_d   = CW'(SETUP_CYC - 1);
      if (is_char(nstep)) begin
        ci_d = char_idx(nstep);
      end else begin
        data_d = cmd_byte(nstep);
        rs_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_POWERUP;
      cnt_q   <= CW'(POWERUP_CYC - 1);
      step_q  <= 6'd0;
      ci_q    <= 5'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      ci_q    <= ci_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      on_q    <= 1'b1;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign char_index = ci_q;
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = en_q;
  assign LCD_ON     = on_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

// File: doc/lcd_string_writer.md
Name: lcd_string_writer

Overview:
Drives the DE2 16x2 HD44780-compatible character LCD from the string lookup block. It supplies a 5-bit character index, reads back the 8-bit ASCII code, and generates the LCD bus cycles with enable timing: power-up wait, init commands, line-1 address, 16 characters, line-2 address, then 16 more characters. It sits between the string lookup and the LCD pins and redraws the screen on request.

Parameters:
POWERUP_CYC, 750000, clock cycles to wait after reset before the first write (15 ms at 50 MHz)
SETUP_CYC, 2, cycles with data/RS valid and LCD_EN low before the enable pulse
EN_CYC, 12, cycles LCD_EN is held high
HOLD_CYC, 2, cycles with data/RS held and LCD_EN low after the pulse
EXEC_CYC, 2500, post-write wait for normal commands and characters (50 us)
CLEAR_CYC, 100000, post-write wait after the clear-display command 0x01 (2 ms)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous active-low reset
refresh  in  1  single-cycle request to redraw all 32 characters
char_index  out  5  index into the string lookup (0..31)
char_data  in  8  ASCII code returned for char_index (combinational, same cycle)
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  0 = command, 1 = character data
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  LCD enable strobe
LCD_ON  out  1  LCD power; 1 whenever not in reset
busy  out  1  1 while any write sequence is in progress
done  out  1  1 in IDLE after at least one complete redraw

Behaviour:
- Reset is asynchronous and active-low. One clock (clk).
- Reset values: LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0, char_index=0, busy=1, done=0. The state is POWERUP and step=0.
- After reset deasserts: LCD_ON=1 from the first clock edge.
- Timed states: each lasts exactly N cycles (N>=1). A down-counter loads N-1 on entry, and the state exits when the counter reaches 0.
- States and transitions:
  - POWERUP (POWERUP_CYC) -> SETUP
  - SETUP (SETUP_CYC) -> PULSE
  - PULSE (EN_CYC; LCD_EN=1) -> HOLD
  - HOLD (HOLD_CYC) -> WAIT
  - WAIT (CLEAR_CYC if the step is 2, else EXEC_CYC) -> if step=37: IDLE, else step+1 and SETUP
  - IDLE: on refresh or a pending refresh -> step=4 and SETUP
- Step table (6-bit step, 0..37):
  - 0: cmd 0x38
  - 1: cmd 0x0C
  - 2: cmd 0x01
  - 3: cmd 0x06
  - 4: cmd 0x80
  - 5..20: char, index step-5
  - 21: cmd 0xC0
  - 22..37: char, index step-6
- char_index is registered: it is updated on the cycle entering SETUP for character steps, and holds otherwise.
- Data capture:
  - char_data is sampled into LCD_DATA on the last SETUP cycle, with LCD_RS=1.
  - For command steps, LCD_DATA and LCD_RS=0 are loaded on entry to SETUP.
  - LCD_DATA and LCD_RS are stable from the end of SETUP through the end of HOLD.
- LCD_EN is 1 only in PULSE.
- busy=0 only in IDLE. done is set on entering IDLE and cleared when a new redraw starts.
- Redraws triggered by refresh skip steps 0-3; init runs only after reset.
- A refresh asserted while busy (including during POWERUP or init) sets a pending flag. The flag is consumed on the IDLE entry cycle, so IDLE lasts one cycle and the redraw restarts at step 4. Multiple requests collapse into one.
- A refresh in the same cycle as entering IDLE counts as pending.
- Reset mid-write: outputs return to reset values immediately, including LCD_EN dropping to 0. The pending flag clears and the full init sequence reruns.
- Per-write duration: SETUP_CYC+EN_CYC+HOLD_CYC+wait.

Test Plan:
- Params 4/1/2/1/3/5; release reset -> LCD_ON=1 next edge; first LCD_EN rise 5 cycles after release, LCD_DATA=0x38, LCD_RS=0; EN high exactly 2 cycles.
- Same params -> sequence 0x38,0x0C,0x01,0x06,0x80, 16 chars, 0xC0, 16 chars; gap after 0x01 is 2 cycles longer; done=1 and busy=0 at cycle 272 after release.
- Stub lookup char_data=0x41+char_index -> LCD_RS=1 writes show 0x41..0x50 on line 1 and 0x51..0x60 on line 2; char_index sequence 0..31.
- In IDLE, pulse refresh -> first write is 0x80 (no init), 34 writes total, done falls then rises after 34*7=238 cycles.
- Pulse refresh twice at step 10 -> exactly one extra redraw after completion, starting the cycle after IDLE entry.
- Assert rst_n=0 while LCD_EN=1 at step 15 -> LCD_EN=0 asynchronously; after release, the full sequence restarts with POWERUP and 0x38.
